// File: rtl/serial_pattern_source.sv
// Serial pattern source: debounced step button walks a loaded pattern out MSB-first on w_out.
// Define PATTERN_LOOP_EN to repeat the pattern forever instead of stopping in DONE.
module serial_pattern_source #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int LW             = $clog2(WIDTH + 1),
  localparam int CW             = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [LW-1:0]    len,
  input  logic             step_raw,
  output logic             w_out,
  output logic             step_pulse,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    bit_index
);

  typedef enum logic [1:0] {IDLE, READY, DONE} state_t;

  state_t           state, state_next;
  logic             sync1, sync2, level, level_prev;
  logic [CW-1:0]    count;
  logic             press;
  logic [WIDTH-1:0] pattern_reg, pattern_next, shifted;
  logic [LW-1:0]    len_reg, len_next, len_clamped, bit_index_next, sel;
  logic             w_next, pulse_next, last_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      count      <= '0;
    end else begin
      sync1      <= step_raw;
      sync2      <= sync1;
      level_prev <= level;
      // count only while the sample disagrees with the debounced level
      if (sync2 == level) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign press       = level & ~level_prev;
  assign len_clamped = (len == '0 || len > LW'(WIDTH)) ? LW'(WIDTH) : len;
  assign sel         = len_reg - bit_index - LW'(1);
  assign shifted     = pattern_reg >> sel;
  assign last_bit    = (bit_index == len_reg - LW'(1));

  always_comb begin
    state_next     = state;
    pattern_next   = pattern_reg;
    len_next       = len_reg;
    bit_index_next = bit_index;
    w_next         = w_out;
    pulse_next     = 1'b0;
    // load wins over a coincident press in every state
    if (load) begin
      pattern_next   = pattern_in;
      len_next       = len_clamped;
      bit_index_next = '0;
      state_next     = READY;
    end else if (state == READY && press) begin
      w_next     = shifted[0];
      pulse_next = 1'b1;
`ifdef PATTERN_LOOP_EN
      bit_index_next = last_bit ? '0 : bit_index + LW'(1);
`else
      bit_index_next = bit_index + LW'(1);
      if (last_bit) state_next = DONE;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pattern_reg <= '0;
      len_reg     <= '0;
      bit_index   <= '0;
      w_out       <= 1'b0;
      step_pulse  <= 1'b0;
    end else begin
      state       <= state_next;
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      bit_index   <= bit_index_next;
      w_out       <= w_next;
      step_pulse  <= pulse_next;
    end
  end

  assign busy = (state == READY);
`ifdef PATTERN_LOOP_EN
  assign done = 1'b0;
`else
  assign done = (state == DONE);
`endif

endmodule
